// File: rtl/imem_boot_loader.sv
// imem_boot_loader: clears the instruction memory to NOP, then assembles a
// little-endian byte stream into 32-bit words and writes them from index 0,
// holding the core stalled (and feeding it NOPs) for the whole load.
module imem_boot_loader #(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [10:0] load_len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_instr,
    output logic        core_stall,
    output logic [9:0]  mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [9:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned AW = 10;   // memory word index width
    localparam int unsigned LW = 11;   // length / counter width (holds DEPTH)
    localparam int unsigned DW = 32;   // word width
    localparam int unsigned BW = 2;    // byte-in-word counter width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_widx;
    logic [LW-1:0]   r_clr;
    logic [BW-1:0]   r_bcnt;
    logic [DW-1:0]   r_asm;
    logic            r_done;
    logic            r_err;

    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_len_ok;
    logic            w_clr_last;
    logic [LW-1:0]   w_widx_inc;
    logic            w_last_word;
    logic            w_unused_addr;

    // Request qualification and counter end conditions
    assign w_len_ok      = (load_len != LW'(0)) && (load_len <= LW'(DEPTH));
    assign w_clr_last    = (r_clr == LW'(DEPTH - 1));
    assign w_widx_inc    = r_widx + LW'(1);
    assign w_last_word   = (w_widx_inc == r_len);
    assign w_unused_addr = ^{fetch_addr[31:12], fetch_addr[1:0]};

    // Fetch path: address always passes through, data replaced by NOP while stalled
    assign mem_raddr   = fetch_addr[11:2];
    assign fetch_instr = core_stall ? NOP_WORD : mem_rdata;
    assign load_done   = r_done;
    assign load_err    = r_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory/handshake decode
    always_comb begin
        w_state_nxt = r_state;
        byte_ready  = 1'b0;
        core_stall  = 1'b1;
        mem_we      = 1'b0;
        mem_waddr   = r_widx[AW-1:0];
        mem_wdata   = r_asm;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                core_stall = 1'b0;
                if (load_start) begin
                    if (w_len_ok) begin
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = r_clr[AW-1:0];
                mem_wdata = NOP_WORD;
                if (w_clr_last) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid && (r_bcnt == BW'(3))) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (w_last_word) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                core_stall  = 1'b0;
            end
        endcase
    end

    // Length latch, clear counter, word index and byte assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_widx <= '0;
            r_clr  <= '0;
            r_bcnt <= '0;
            r_asm  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_start && w_len_ok) begin
                        r_len  <= load_len;
                        r_widx <= '0;
                        r_clr  <= '0;
                        r_bcnt <= '0;
                    end
                end
                S_CLEAR: begin
                    r_clr <= r_clr + LW'(1);
                end
                S_LOAD: begin
                    if (byte_valid) begin
                        r_asm[{r_bcnt, 3'b000} +: 8] <= byte_data;
                        r_bcnt                       <= r_bcnt + BW'(1);
                    end
                end
                S_WRITE: begin
                    r_widx <= w_widx_inc;
                end
                default: begin
                    r_bcnt <= '0;
                end
            endcase
        end
    end

    // One-cycle completion and rejection pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction memory depth in 32-bit words.
REQ-002 Parameter NOP_WORD, default 32'h00000013, fill value and stall-time instruction.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port load_start  input  1  one-cycle request to begin a program load.
REQ-006 Port load_len  input  11  number of words to load, sampled with load_start.
REQ-007 Port byte_valid  input  1  loader byte stream valid.
REQ-008 Port byte_data  input  8  loader byte, little-endian within a word.
REQ-009 Port byte_ready  output  1  block accepts a byte this cycle.
REQ-010 Port fetch_addr  input  32  core fetch byte address.
REQ-011 Port fetch_instr  output  32  instruction returned to core.
REQ-012 Port core_stall  output  1  core must hold its PC.
REQ-013 Port mem_raddr  output  10  memory read word index.
REQ-014 Port mem_rdata  input  32  memory combinational read data.
REQ-015 Port mem_we, mem_waddr, mem_wdata  output  1/10/32  memory write port.
REQ-016 Port load_done  output  1  one-cycle pulse on successful completion.
REQ-017 Port load_err  output  1  one-cycle pulse on rejected load_start.

Function
REQ-018 States IDLE, CLEAR, LOAD, WRITE; reset state IDLE.
REQ-019 mem_raddr SHALL equal fetch_addr[11:2] in all states; fetch_addr[1:0] ignored.
REQ-020 fetch_instr SHALL equal mem_rdata when core_stall=0, NOP_WORD when core_stall=1 (combinational).
REQ-021 core_stall SHALL be 1 in CLEAR, LOAD, WRITE; 0 in IDLE.
REQ-022 IDLE: load_start with 1<=load_len<=DEPTH -> CLEAR, latch load_len, clear word index and byte count.
REQ-023 IDLE: load_start with load_len=0 or >DEPTH -> stay IDLE, load_err=1 next cycle for one cycle.
REQ-024 load_start outside IDLE SHALL be ignored (no error, no restart).
REQ-025 CLEAR: mem_we=1, mem_wdata=NOP_WORD, mem_waddr=clear counter 0..DEPTH-1, one word per cycle; after index DEPTH-1 -> LOAD; CLEAR lasts exactly DEPTH cycles.
REQ-026 byte_ready SHALL be 1 only in LOAD; 0 in IDLE, CLEAR, WRITE.
REQ-027 LOAD: byte accepted iff byte_valid&byte_ready; byte k (k=0..3) placed in word bits [8k+7:8k]; 2-bit byte count increments per accept.
REQ-028 LOAD: acceptance of byte 3 -> WRITE; byte count wraps to 0.
REQ-029 WRITE: single cycle, mem_we=1, mem_waddr=word index, mem_wdata=assembled word; word index increments.
REQ-030 WRITE: if incremented index equals latched load_len -> IDLE with load_done=1 that cycle-after (one-cycle pulse on IDLE entry); else -> LOAD.
REQ-031 Minimum load time SHALL be DEPTH + 5*load_len cycles from load_start (byte_valid held high).
REQ-032 byte_valid gaps in LOAD SHALL stall assembly without loss; partial words held indefinitely.
REQ-033 mem_we SHALL be 0 in IDLE and LOAD.
REQ-034 load_done and load_err SHALL never assert in the same cycle.

Reset
REQ-035 rst_n low SHALL immediately force IDLE; core_stall=0, byte_ready=0, mem_we=0, load_done=0, load_err=0, all counters and assembly register 0.
REQ-036 Reset mid-CLEAR/LOAD SHALL abandon the load; memory contents left as partially written; no load_done.

Verification
REQ-037 Reset, fetch_addr=32'h8, mem_rdata=32'h00500093 -> mem_raddr=2, fetch_instr=32'h00500093, core_stall=0.
REQ-038 load_start, load_len=2, bytes 93 00 50 00 13 01 A0 00 back-to-back -> 1024 NOP writes, then writes [0]=32'h00500093, [1]=32'h00A00113, load_done pulse at cycle 1024+10, core_stall 1 throughout.
REQ-039 load_start with load_len=0 and again with 1025 -> load_err one-cycle pulse each, state IDLE, no mem_we.
REQ-040 load_len=1, byte_valid deasserted 3 cycles between bytes 1 and 2 -> word assembled correctly, single WRITE, load_done.
REQ-041 rst_n low during LOAD after 2 bytes -> outputs at reset values immediately; following load_start restarts with CLEAR at index 0.
REQ-042 load_start pulsed during CLEAR -> ignored; clear counter and latched load_len unchanged.
